// File: rtl/button_debounce_reader.sv
// Button input conditioner: 2-flop synchroniser, debounce FSM, press/release/long pulses, press counter.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_debounce_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 12_500_000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned MAX_DL = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned MAXC   = (REPEAT_CYCLES > MAX_DL) ? REPEAT_CYCLES : MAX_DL;
  localparam int unsigned CW     = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t           state, state_d;
  logic             sync1, sync2, s;
  logic [CW-1:0]    db_cnt, db_cnt_d, hold_cnt, hold_cnt_d;
  logic             level_d, press_d, release_d, long_d;
  logic [CNT_W-1:0] count_d;

  // Flops reset to the released pin level so a held button is seen as a fresh press
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ ACTIVE_LOW;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rpt_cnt, rpt_cnt_d;
  logic          repeat_d;
`endif

  always_comb begin
    state_d    = state;
    db_cnt_d   = db_cnt;
    hold_cnt_d = hold_cnt;
    level_d    = btn_level;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    count_d    = press_count;
`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_d  = rpt_cnt;
    repeat_d   = 1'b0;
`endif
    case (state)
      IDLE: begin
        level_d = 1'b0;
        if (s) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d    = HELD;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          level_d    = 1'b1;
          press_d    = 1'b1;
          count_d    = press_count + CNT_W'(1);
`ifdef BTN_AUTOREPEAT_EN
          rpt_cnt_d  = '0;
`endif
        end else begin
          db_cnt_d = db_cnt + CW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = CW'(1);
        end else if (hold_cnt != LONG_MAX) begin
          hold_cnt_d = hold_cnt + CW'(1);
          long_d     = (hold_cnt == LONG_LAST);
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          // Repeat timer only runs once the long press has been reported
          if (rpt_cnt == RPT_LAST) begin
            rpt_cnt_d = '0;
            repeat_d  = 1'b1;
            count_d   = press_count + CNT_W'(1);
          end else begin
            rpt_cnt_d = rpt_cnt + CW'(1);
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d    = IDLE;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          level_d    = 1'b0;
          release_d  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rpt_cnt_d  = '0;
`endif
        end else begin
          db_cnt_d = db_cnt + CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= '0;
    end else begin
      state         <= state_d;
      db_cnt        <= db_cnt_d;
      hold_cnt      <= hold_cnt_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      press_count   <= count_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rpt_cnt      <= rpt_cnt_d;
      repeat_pulse <= repeat_d;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_reader.sv
// Scoreboard bench for button_debounce_reader: expected pulse events are queued at stimulus time.
module tb_button_debounce_reader;

  localparam int DB = 4;
  localparam int LG = 10;
  localparam int RP = 3;

  localparam int K_PRESS   = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;
  localparam int K_RELEASE = 4;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b0;
  logic       btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [1:0] press_count;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   exp_cnt = 0;
  ev_t  q[$];

  button_debounce_reader #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LG),
    .REPEAT_CYCLES(RP),
    .ACTIVE_LOW(1'b0),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse),
    .press_count(press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int n);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.cnt  = n;
    q.push_back(e);
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (q.size() == 0) begin
      check("spurious_pulse", kind, 0);
    end else begin
      e = q.pop_front();
      check("ev_kind", kind, e.kind);
      check("ev_cycle", cyc, e.cyc);
      check("ev_count", int'(press_count), e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (press_pulse)   take(K_PRESS);
    if (long_pulse)    take(K_LONG);
    if (repeat_pulse)  take(K_REPEAT);
    if (release_pulse) take(K_RELEASE);
    if (press_pulse && release_pulse) check("press_release_excl", 1, 0);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press held for `hold` cycles past press_pulse, then released.
  task automatic press(input int hold);
    int p, t2;
    p  = cyc + 2 + DB;
    t2 = p + hold;
    exp_cnt = (exp_cnt + 1) % 4;
    push(K_PRESS, p, exp_cnt);
    // HELD sees the pressed level up to two cycles after the pin drops
    if (p + LG <= t2 + 2) push(K_LONG, p + LG, exp_cnt);
`ifdef BTN_AUTOREPEAT_EN
    for (int k = p + LG + RP; k <= t2 + 2; k += RP) begin
      exp_cnt = (exp_cnt + 1) % 4;
      push(K_REPEAT, k, exp_cnt);
    end
`endif
    push(K_RELEASE, t2 + 2 + DB, exp_cnt);
    btn_in = 1'b1;
    tick(2 + DB);
    check("level_pressed", int'(btn_level), 1);
    tick(hold);
    btn_in = 1'b0;
    tick(2 + DB);
    check("level_released", int'(btn_level), 0);
    tick(2);
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bseq[7] = '{1, 1, 0, 1, 1, 1, 0};
    int t;

    tick(3);
    check("rst_level", int'(btn_level), 0);
    check("rst_press", int'(press_pulse), 0);
    check("rst_release", int'(release_pulse), 0);
    check("rst_long", int'(long_pulse), 0);
    check("rst_repeat", int'(repeat_pulse), 0);
    check("rst_count", int'(press_count), 0);
    rst = 1'b0;
    tick(2);

    foreach (bseq[i]) begin
      btn_in = (bseq[i] != 0);
      tick(1);
    end
    btn_in = 1'b0;
    tick(10);
    check("bounce_level", int'(btn_level), 0);
    check("bounce_count", int'(press_count), 0);
    check("bounce_queue", q.size(), 0);

    press(3);
    press(20);
    for (int i = 0; i < 4; i++) press(2);

    // Reset two cycles into PRESS_WAIT
    t = cyc;
    btn_in = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    check("midrst_level", int'(btn_level), 0);
    check("midrst_count", int'(press_count), 0);
    rst = 1'b0;
    exp_cnt = 1;
    push(K_PRESS, t + 5 + 2 + DB, exp_cnt);
    push(K_RELEASE, t + 5 + 2 + DB + 2 + 2 + DB, exp_cnt);
    tick(2 + DB);
    check("midrst_pressed", int'(btn_level), 1);
    tick(2);
    btn_in = 1'b0;
    tick(2 + DB + 2);
    check("midrst_queue", q.size(), 0);

    press(23);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
